// File: rtl/avalon_arb_pkg.sv
// Shared types and sizing helpers for the two-master Avalon-MM memory arbiter.
package avalon_arb_pkg;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_ACC = 1'b1
  } master_id_t;

  // Width needed to hold an occupancy count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Tag FIFO remembering which master issued each accepted read, popped per response.
module arb_tag_fifo
  import avalon_arb_pkg::*;
#(
  parameter int PENDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  master_id_t                  push_id,
  input  logic                        pop,
  output master_id_t                  head_id,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_w(PENDING)-1:0]   count
);

  localparam int PTR_W = $clog2(PENDING);
  localparam int CNT_W = cnt_w(PENDING);

  master_id_t       slots [PENDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(PENDING));
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign head_id = slots[rd_ptr];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master (CPU, accelerator) to one-slave Avalon-MM arbiter with pipelined read routing.
// Define ARB_FIXED_PRI_EN to give the CPU fixed priority instead of round-robin.
module avalon_mem_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PENDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cpu_waitrequest,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              acc_waitrequest,
  input  logic [ADDR_W-1:0] acc_address,
  input  logic              acc_read,
  output logic [DATA_W-1:0] acc_readdata,
  output logic              acc_readdatavalid,
  input  logic              acc_write,
  input  logic [DATA_W-1:0] acc_writedata,
  input  logic              mem_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              err_orphan
);

  localparam int CNT_W = cnt_w(PENDING);

  logic              req_cpu, req_acc;
  logic              gnt_vld;
  master_id_t        gnt_id;
  logic              lock;
  master_id_t        owner, last_grant;
  logic              g_read, g_write;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              read_stall, mem_req, accept, gnt_ok, rsp_pop;
  logic              fifo_full, fifo_empty;
  master_id_t        head_id;
  logic [CNT_W-1:0]  tag_count;

  assign req_cpu = cpu_read | cpu_write;
  assign req_acc = acc_read | acc_write;

  // A locked transfer keeps the slave signals stable until it is accepted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ID_CPU;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_id  = owner;
    end else if (req_cpu && req_acc) begin
      gnt_vld = 1'b1;
`ifdef ARB_FIXED_PRI_EN
      gnt_id  = ID_CPU;
`else
      gnt_id  = (last_grant == ID_CPU) ? ID_ACC : ID_CPU;
`endif
    end else if (req_cpu) begin
      gnt_vld = 1'b1;
      gnt_id  = ID_CPU;
    end else if (req_acc) begin
      gnt_vld = 1'b1;
      gnt_id  = ID_ACC;
    end
  end

  always_comb begin
    g_read  = 1'b0;
    g_write = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    if (gnt_vld && !rst) begin
      if (gnt_id == ID_CPU) begin
        g_read  = cpu_read;
        g_write = cpu_write;
        g_addr  = cpu_address;
        g_wdata = cpu_writedata;
      end else begin
        g_read  = acc_read;
        g_write = acc_write;
        g_addr  = acc_address;
        g_wdata = acc_writedata;
      end
    end
  end

  // A full tag FIFO holds back reads only; writes need no tag.
  assign read_stall    = g_read & fifo_full;
  assign mem_read      = g_read & !read_stall;
  assign mem_write     = g_write;
  assign mem_address   = g_addr;
  assign mem_writedata = g_wdata;
  assign mem_req       = mem_read | mem_write;
  assign accept        = mem_req & !mem_waitrequest;

  assign gnt_ok          = gnt_vld & !rst & !mem_waitrequest & !read_stall;
  assign cpu_waitrequest = !(gnt_ok && gnt_id == ID_CPU);
  assign acc_waitrequest = !(gnt_ok && gnt_id == ID_ACC);

  assign rsp_pop           = mem_readdatavalid & !fifo_empty & !rst;
  assign cpu_readdatavalid = rsp_pop && head_id == ID_CPU;
  assign acc_readdatavalid = rsp_pop && head_id == ID_ACC;
  assign cpu_readdata      = mem_readdata;
  assign acc_readdata      = mem_readdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      owner      <= ID_CPU;
      last_grant <= ID_ACC;
      err_orphan <= 1'b0;
    end else begin
      if (mem_req && mem_waitrequest) begin
        lock  <= 1'b1;
        owner <= gnt_id;
      end else if (accept) begin
        lock       <= 1'b0;
        last_grant <= gnt_id;
      end
      if (mem_readdatavalid && tag_count == '0) err_orphan <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .PENDING (PENDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept & mem_read),
    .push_id (gnt_id),
    .pop     (rsp_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (tag_count)
  );

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Scoreboard bench for avalon_mem_arbiter: stimulus queues expected slave acceptances
// and read responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_avalon_mem_arbiter;
  import avalon_arb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int PENDING = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_waitrequest, cpu_read, cpu_write, cpu_readdatavalid;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_readdata, cpu_writedata;
  logic              acc_waitrequest, acc_read, acc_write, acc_readdatavalid;
  logic [ADDR_W-1:0] acc_address;
  logic [DATA_W-1:0] acc_readdata, acc_writedata;
  logic              mem_waitrequest, mem_read, mem_write, mem_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_readdata, mem_writedata;
  logic              err_orphan;

  avalon_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PENDING (PENDING)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_readdata      (cpu_readdata),
    .cpu_readdatavalid (cpu_readdatavalid),
    .cpu_write         (cpu_write),
    .cpu_writedata     (cpu_writedata),
    .acc_waitrequest   (acc_waitrequest),
    .acc_address       (acc_address),
    .acc_read          (acc_read),
    .acc_readdata      (acc_readdata),
    .acc_readdatavalid (acc_readdatavalid),
    .acc_write         (acc_write),
    .acc_writedata     (acc_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .err_orphan        (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk_acc(input logic id, input logic wr,
                                  input logic [31:0] a, input logic [31:0] d);
    acc_t t;
    t.id = id; t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic rsp_t mk_rsp(input logic id, input logic [31:0] d);
    rsp_t t;
    t.id = id; t.data = d;
    return t;
  endfunction

  // Monitor: compares every slave acceptance and every forwarded read response.
  always @(negedge clk) begin : monitor
    acc_t e;
    rsp_t r;
    if (rst === 1'b0) begin
      if ((mem_read || mem_write) && !mem_waitrequest) begin
        if (exp_acc.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_accept: got addr %0h required none (t=%0t)", mem_address, $time);
        end else begin
          e = exp_acc.pop_front();
          chk("accept_cpu_waitreq", cpu_waitrequest, (e.id == ID_CPU) ? 0 : 1);
          chk("accept_acc_waitreq", acc_waitrequest, (e.id == ID_ACC) ? 0 : 1);
          chk("accept_addr", mem_address, e.addr);
          chk("accept_write", mem_write, e.wr);
          if (e.wr) chk("accept_wdata", mem_writedata, e.data);
        end
      end
      if (cpu_readdatavalid || acc_readdatavalid) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_response: got cpu_rdv %0b acc_rdv %0b required none (t=%0t)",
                   cpu_readdatavalid, acc_readdatavalid, $time);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_cpu_rdv", cpu_readdatavalid, (r.id == ID_CPU) ? 1 : 0);
          chk("rsp_acc_rdv", acc_readdatavalid, (r.id == ID_ACC) ? 1 : 0);
          chk("rsp_cpu_data", cpu_readdata, r.data);
          chk("rsp_acc_data", acc_readdata, r.data);
        end
      end
    end
  end

  task automatic clr();
    cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_writedata = '0;
    acc_read = 0; acc_write = 0; acc_address = '0; acc_writedata = '0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    clr();
    rst = 1'b1;
    cpu_write = 1'b1; cpu_address = 32'hAAAA; acc_read = 1'b1;
    mem_readdatavalid = 1'b1;
    repeat (2) nxt();
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_cpu_waitreq", cpu_waitrequest, 1);
    chk("reset_acc_waitreq", acc_waitrequest, 1);
    chk("reset_cpu_rdv", cpu_readdatavalid, 0);
    chk("reset_acc_rdv", acc_readdatavalid, 0);
    chk("reset_err_orphan", err_orphan, 0);
    clr();
    rst = 1'b0;
    nxt();

    // Contention: both write every cycle; first winner is cpu since last_grant resets to acc.
    cpu_write = 1; cpu_address = 32'h10; cpu_writedata = 32'hC0C0_0001;
    acc_write = 1; acc_address = 32'h20; acc_writedata = 32'hACC0_0002;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_acc.push_back(mk_acc(ID_CPU, 1'b1, 32'h10, 32'hC0C0_0001));
      else            exp_acc.push_back(mk_acc(ID_ACC, 1'b1, 32'h20, 32'hACC0_0002));
    end
    repeat (4) nxt();
    clr();

    // Single acc read, response three cycles later.
    acc_read = 1; acc_address = 32'h100;
    exp_acc.push_back(mk_acc(ID_ACC, 1'b0, 32'h100, 32'h0));
    @(negedge clk);
    chk("single_addr", mem_address, 32'h100);
    chk("single_read", mem_read, 1);
    nxt();
    clr();
    nxt(); nxt();
    mem_readdatavalid = 1; mem_readdata = 32'hDEADBEEF;
    exp_rsp.push_back(mk_rsp(ID_ACC, 32'hDEADBEEF));
    @(negedge clk);
    chk("single_cpu_rdv", cpu_readdatavalid, 0);
    chk("single_acc_rdv", acc_readdatavalid, 1);
    chk("single_acc_data", acc_readdata, 32'hDEADBEEF);
    nxt();
    clr();

    // Lock under stall: acc held for 4 stalled cycles while cpu also requests.
    acc_write = 1; acc_address = 32'h200; acc_writedata = 32'h1234;
    mem_waitrequest = 1;
    exp_acc.push_back(mk_acc(ID_ACC, 1'b1, 32'h200, 32'h1234));
    exp_acc.push_back(mk_acc(ID_CPU, 1'b1, 32'h300, 32'h5678));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin cpu_write = 1; cpu_address = 32'h300; cpu_writedata = 32'h5678; end
      if (c == 4) mem_waitrequest = 0;
      @(negedge clk);
      chk("lock_addr", mem_address, 32'h200);
      chk("lock_wdata", mem_writedata, 32'h1234);
      chk("lock_cpu_waitreq", cpu_waitrequest, 1);
      nxt();
    end
    acc_write = 0;
    @(negedge clk);
    chk("lock_then_cpu_addr", mem_address, 32'h300);
    nxt();
    clr();

    // Pipelined reads: cpu, acc, cpu, acc fill the tag FIFO; fifth read stalls.
    exp_acc.push_back(mk_acc(ID_CPU, 1'b0, 32'h400, 32'h0));
    exp_acc.push_back(mk_acc(ID_ACC, 1'b0, 32'h500, 32'h0));
    exp_acc.push_back(mk_acc(ID_CPU, 1'b0, 32'h400, 32'h0));
    exp_acc.push_back(mk_acc(ID_ACC, 1'b0, 32'h500, 32'h0));
    exp_acc.push_back(mk_acc(ID_CPU, 1'b0, 32'h400, 32'h0));
    cpu_read = 1; cpu_address = 32'h400;
    nxt();
    acc_read = 1; acc_address = 32'h500;
    nxt(); nxt(); nxt();
    acc_read = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("stall_mem_read", mem_read, 0);
      chk("stall_cpu_waitreq", cpu_waitrequest, 1);
      nxt();
    end
    mem_readdatavalid = 1; mem_readdata = 32'hD000;
    exp_rsp.push_back(mk_rsp(ID_CPU, 32'hD000));
    @(negedge clk);
    chk("stall_hold_on_pop", mem_read, 0);
    nxt();
    mem_readdata = 32'hD001;
    exp_rsp.push_back(mk_rsp(ID_ACC, 32'hD001));
    @(negedge clk);
    chk("stall_release", mem_read, 1);
    nxt();
    cpu_read = 0;
    for (int c = 0; c < 3; c++) begin
      mem_readdata = 32'hD002 + c;
      exp_rsp.push_back(mk_rsp((c == 1) ? ID_ACC : ID_CPU, 32'hD002 + c));
      nxt();
    end
    clr();

    // Orphan response with an empty tag FIFO.
    @(negedge clk);
    chk("orphan_pre", err_orphan, 0);
    nxt();
    mem_readdatavalid = 1; mem_readdata = 32'hBAD;
    @(negedge clk);
    chk("orphan_cpu_rdv", cpu_readdatavalid, 0);
    chk("orphan_acc_rdv", acc_readdatavalid, 0);
    nxt();
    clr();
    @(negedge clk);
    chk("orphan_set", err_orphan, 1);
    nxt(); nxt();
    @(negedge clk);
    chk("orphan_hold", err_orphan, 1);
    nxt();

    // Async reset mid-lock with two reads outstanding.
    cpu_read = 1; cpu_address = 32'h600;
    exp_acc.push_back(mk_acc(ID_CPU, 1'b0, 32'h600, 32'h0));
    nxt();
    cpu_read = 0; acc_read = 1; acc_address = 32'h700;
    exp_acc.push_back(mk_acc(ID_ACC, 1'b0, 32'h700, 32'h0));
    nxt();
    acc_read = 0; cpu_write = 1; cpu_address = 32'h800; cpu_writedata = 32'h99;
    mem_waitrequest = 1;
    nxt(); nxt();
    chk("prereset_write", mem_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_mem_read", mem_read, 0);
    chk("async_mem_write", mem_write, 0);
    chk("async_cpu_waitreq", cpu_waitrequest, 1);
    chk("async_acc_waitreq", acc_waitrequest, 1);
    chk("async_err_orphan", err_orphan, 0);
    nxt();
    clr();
    rst = 1'b0;
    mem_readdatavalid = 1; mem_readdata = 32'h600D;
    @(negedge clk);
    chk("late_cpu_rdv", cpu_readdatavalid, 0);
    chk("late_acc_rdv", acc_readdatavalid, 0);
    nxt();
    clr();
    @(negedge clk);
    chk("late_orphan", err_orphan, 1);
    nxt();
    acc_write = 1; acc_address = 32'h900; acc_writedata = 32'h77;
    exp_acc.push_back(mk_acc(ID_ACC, 1'b1, 32'h900, 32'h77));
    nxt();
    clr();
    nxt(); nxt();

    chk("accept_queue_drained", exp_acc.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
